// File: rtl/data_memory.sv
// Word-organised data RAM for LDR/STR traffic: req/ready handshake,
// programmable wait states, misalign/range error flag, registered load data.
module data_memory #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [16:0] LIMIT = 17'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          req_q;
    logic          rw_q;
    logic [15:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rd_data_q;
    logic          err_q;
    logic [31:0]   mem_q [DEPTH];

    logic          capture;
    logic          do_access;
    logic          bad;
    logic [AW-1:0] idx;

    assign bad = (addr_q[1:0] != 2'b00) | ({1'b0, addr_q} >= LIMIT);
    assign idx = addr_q[AW+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        do_access = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req & ~req_q) begin
                    capture = 1'b1;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 32'd0;
        end else if (capture) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wr_data;
        end
    end

    // Errored reads return zero; errored writes leave the array untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else if (do_access) begin
            err_q <= bad;
            if (!rw_q) begin
                rd_data_q <= bad ? 32'd0 : mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (do_access && rw_q && !bad) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign rd_data = rd_data_q;
    assign ready   = (state_q == RESP);
    assign busy    = (state_q != IDLE);
    assign err     = err_q & (state_q == RESP);

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed vector table, handshake/reset sequences,
// and random traffic checked against an array model.
module tb_data_memory;

    localparam int DEPTH = 16;
    localparam int W     = 1;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        rw;
    logic [15:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic        busy;
    logic        err;

    data_memory #(
        .DEPTH(DEPTH),
        .WAIT_CYCLES(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .rw(rw),
        .addr(addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .ready(ready),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] mdl_rd;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
        mdl_rd = 32'd0;
    endtask

    task automatic model_op(input logic r_w, input logic [15:0] a,
                            input logic [31:0] d, output logic [31:0] erd,
                            output logic eerr);
        logic oops;
        oops = (a % 4 != 0) || (int'(a) >= 4 * DEPTH);
        if (r_w) begin
            if (!oops) mdl[a / 4] = d;
        end else begin
            mdl_rd = oops ? 32'd0 : mdl[a / 4];
        end
        erd  = mdl_rd;
        eerr = oops;
    endtask

    // One complete transaction; returns sampled results and timing.
    task automatic txn(input logic r_w, input logic [15:0] a,
                       input logic [31:0] d, output logic [31:0] grd,
                       output logic gerr, output int edges,
                       output int busyc);
        @(negedge clk);
        rw      = r_w;
        addr    = a;
        wr_data = d;
        req     = 1'b1;
        edges   = 0;
        busyc   = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (busy) busyc++;
        end while (!ready && edges < 50);
        if (!ready) begin
            bad++;
            total++;
            $display("FAIL timeout addr=%h got=no_ready want=ready", a);
        end
        grd  = rd_data;
        gerr = err;
        req  = 1'b0;
        @(negedge clk);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] grd, erd;
    logic        gerr, eerr;
    int          edges, busyc, pulses;

    initial begin
        rst_n   = 1'b0;
        req     = 1'b0;
        rw      = 1'b0;
        addr    = 16'd0;
        wr_data = 32'd0;
        model_reset();

        vecs[0]  = '{1'b0, 16'h0008, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1, 16'h0004, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 16'h0004, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 16'h0000, 32'h11111111, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 16'h003C, 32'h22222222, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 32'h0,        32'h11111111, 1'b0};
        vecs[6]  = '{1'b0, 16'h003C, 32'h0,        32'h22222222, 1'b0};
        vecs[7]  = '{1'b1, 16'h0040, 32'hAAAAAAAA, 32'h22222222, 1'b1};
        vecs[8]  = '{1'b0, 16'h0040, 32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b0, 16'h0006, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b1, 16'h0005, 32'h12345678, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 16'h0004, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[12] = '{1'b0, 16'h003C, 32'h0,        32'h22222222, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 32'h0,        32'h11111111, 1'b0};

        #12;
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            txn(vecs[i].rw, vecs[i].addr, vecs[i].wd, grd, gerr, edges, busyc);
            model_op(vecs[i].rw, vecs[i].addr, vecs[i].wd, erd, eerr);
            check($sformatf("vec%0d_rd", i), grd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'd0, gerr},
                  {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), edges, W + 2);
            check($sformatf("vec%0d_busy", i), busyc, W + 2);
        end

        // req held high across two completion windows: one pulse only.
        @(negedge clk);
        rw     = 1'b0;
        addr   = 16'h0000;
        req    = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3 * (W + 4); c++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check("hold_pulses", pulses, 1);
        check("hold_rd", rd_data, 32'h11111111);
        req = 1'b0;
        @(negedge clk);

        // Inputs wiggle during ACCESS; latched write must complete as is.
        rw      = 1'b1;
        addr    = 16'h0008;
        wr_data = 32'h55AA55AA;
        req     = 1'b1;
        @(negedge clk);
        req     = 1'b0;
        addr    = 16'h000C;
        rw      = 1'b0;
        wr_data = 32'h0BADF00D;
        pulses  = 0;
        if (ready) pulses++;
        @(negedge clk);
        req = 1'b1;
        if (ready) pulses++;
        @(negedge clk);
        req = 1'b0;
        if (ready) pulses++;
        check("wiggle_err", {31'd0, err}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check("wiggle_pulses", pulses, 1);
        model_op(1'b1, 16'h0008, 32'h55AA55AA, erd, eerr);
        txn(1'b0, 16'h0008, 32'h0, grd, gerr, edges, busyc);
        model_op(1'b0, 16'h0008, 32'h0, erd, eerr);
        check("wiggle_rd8", grd, erd);
        txn(1'b0, 16'h000C, 32'h0, grd, gerr, edges, busyc);
        model_op(1'b0, 16'h000C, 32'h0, erd, eerr);
        check("wiggle_rdC", grd, erd);

        // Reset mid-write: outputs drop at once, write lost, array cleared.
        @(negedge clk);
        rw      = 1'b1;
        addr    = 16'h0010;
        wr_data = 32'hCAFEF00D;
        req     = 1'b1;
        @(negedge clk);
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_ready", {31'd0, ready}, 32'd0);
        check("mid_rd", rd_data, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 16'h0010, 32'h0, grd, gerr, edges, busyc);
        check("mid_rd10", grd, 32'd0);
        check("mid_err10", {31'd0, gerr}, 32'd0);
        txn(1'b0, 16'h0004, 32'h0, grd, gerr, edges, busyc);
        check("mid_rd4", grd, 32'd0);
        model_op(1'b0, 16'h0004, 32'h0, erd, eerr);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            logic        r_w;
            logic [15:0] a;
            logic [31:0] d;
            r_w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 90));
            else a = 16'($urandom_range(0, DEPTH - 1) * 4);
            d = $urandom;
            txn(r_w, a, d, grd, gerr, edges, busyc);
            model_op(r_w, a, d, erd, eerr);
            check($sformatf("rnd%0d_rd", i), grd, erd);
            check($sformatf("rnd%0d_err", i), {31'd0, gerr}, {31'd0, eerr});
            check($sformatf("rnd%0d_lat", i), edges, W + 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
